// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder/subtractor. One full-adder cell and a registered carry
//   process two WIDTH-bit operands one bit per clock, LSB first, under a
//   start/busy/done handshake.
//
// Parameters:
//   WIDTH  operand and result width in bits (>= 1)
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request; sampled only in IDLE or DONE
//   sub    in   0 = add, 1 = subtract; captured with start
//   a      in   operand A; captured with start
//   b      in   operand B; captured with start
//   cin    in   carry-in for add; captured with start; ignored when sub=1
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse; sum/cout/ovf just updated
//   sum    out  result; held until the next completion
//   cout   out  carry-out of the MSB (for subtract: 1 = no borrow)
//   ovf    out  two's-complement signed overflow of the result

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    // Subtraction is A + ~B + 1, so only the B operand and the first carry
    // differ between the two modes.
    logic [WIDTH-1:0] eff_b;
    logic             init_carry;

    // Full-adder cell and next result shift value.
    logic             bit_sum;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_nxt;
    logic             last_bit;

    assign eff_b      = sub ? ~b : b;
    assign init_carry = sub ? 1'b1 : cin;

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
        carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
        // Written as shift-then-insert so WIDTH=1 needs no special case.
        res_nxt            = res_sh >> 1;
        res_nxt[WIDTH-1]   = bit_sum;
        last_bit           = (cnt == CW'(WIDTH - 1));
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // DONE accepts a new start so operations can run back to back.
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= eff_b;
                        carry <= init_carry;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= eff_b[WIDTH-1];
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    carry  <= carry_nxt;
                    res_sh <= res_nxt;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        sum   <= res_nxt;
                        cout  <= carry_nxt;
                        // Overflow: operands share a sign that the result lacks.
                        ovf   <= (a_msb == b_msb) && (bit_sum != a_msb);
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Drives a WIDTH=8 and a WIDTH=1 serial_adder with directed vectors.
//   A transaction-level model (integer add of the captured operands, a
//   countdown to completion) predicts busy/done/sum/cout/ovf for every cycle;
//   directed tests additionally pin results to hand-computed literals.

module tb_serial_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: WIDTH=8 instance, index 1: WIDTH=1 instance.
    logic       rst_v   [2];
    logic       start_v [2];
    logic       sub_v   [2];
    logic [7:0] a_v     [2];
    logic [7:0] b_v     [2];
    logic       cin_v   [2];

    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic       busy1, done1, cout1, ovf1;
    logic [0:0] sum1;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .sub(sub_v[0]),
        .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .sub(sub_v[1]),
        .a(a_v[1][0:0]), .b(b_v[1][0:0]), .cin(cin_v[1]),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: plain integer addition of the width-masked operands.
    function automatic res_t ref_add(input int w, input logic [7:0] a, input logic [7:0] b,
                                     input logic sub, input logic cin);
        logic [7:0] mask;
        logic [7:0] eb;
        logic [8:0] full;
        res_t       r;
        mask   = 8'((9'd1 << w) - 9'd1);
        eb     = (sub ? ~b : b) & mask;
        full   = {1'b0, a & mask} + {1'b0, eb} + {8'd0, (sub ? 1'b1 : cin)};
        r.sum  = full[7:0] & mask;
        r.cout = full[w];
        r.ovf  = (a[w-1] == eb[w-1]) && (r.sum[w-1] != a[w-1]);
        return r;
    endfunction

    // Transaction model: an accepted start schedules its result WIDTH edges later.
    bit   m_run  [2] = '{1'b0, 1'b0};
    bit   m_done [2] = '{1'b0, 1'b0};
    int   m_left [2] = '{0, 0};
    res_t m_res  [2] = '{'0, '0};
    res_t m_pend [2] = '{'0, '0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_v[k]) begin
                m_run[k]  <= 1'b0;
                m_done[k] <= 1'b0;
                m_left[k] <= 0;
                m_res[k]  <= '0;
            end else if (m_run[k]) begin
                m_left[k] <= m_left[k] - 1;
                if (m_left[k] == 1) begin
                    m_run[k]  <= 1'b0;
                    m_done[k] <= 1'b1;
                    m_res[k]  <= m_pend[k];
                end else begin
                    m_done[k] <= 1'b0;
                end
            end else begin
                m_done[k] <= 1'b0;
                if (start_v[k]) begin
                    m_run[k]  <= 1'b1;
                    m_left[k] <= (k == 0) ? 8 : 1;
                    m_pend[k] <= ref_add((k == 0) ? 8 : 1, a_v[k], b_v[k], sub_v[k], cin_v[k]);
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cycle_w8", {20'd0, busy8, done8, cout8, ovf8, sum8},
                  {20'd0, m_run[0], m_done[0], m_res[0].cout, m_res[0].ovf, m_res[0].sum});
            check("cycle_w1", {20'd0, busy1, done1, cout1, ovf1, 7'd0, sum1},
                  {20'd0, m_run[1], m_done[1], m_res[1].cout, m_res[1].ovf, m_res[1].sum});
        end
    end

    // One WIDTH=8 operation: start for one cycle, scramble operands, wait for done.
    task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic sub, input logic cin,
                        input logic [7:0] e_sum, input logic e_cout, input logic e_ovf);
        int lat;
        a_v[0] = a; b_v[0] = b; sub_v[0] = sub; cin_v[0] = cin; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        a_v[0] = ~a; b_v[0] = a ^ b; sub_v[0] = ~sub; cin_v[0] = ~cin;
        lat = 1;
        while (!done8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, 9);
        check({name, "_sum"}, sum8, e_sum);
        check({name, "_cout_ovf"}, {cout8, ovf8}, {e_cout, e_ovf});
    endtask

    initial begin
        logic [7:0] fa_sum_tbl;
        logic [7:0] fa_cout_tbl;
        int         done_at [$];
        bit         seen_done;

        for (int k = 0; k < 2; k++) begin
            rst_v[k] = 1'b1; start_v[k] = 1'b0; sub_v[k] = 1'b0;
            a_v[k] = '0; b_v[k] = '0; cin_v[k] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        cmp_en = 1'b1;
        check("reset_w8", {busy8, done8, cout8, ovf8, sum8}, 12'h000);
        @(negedge clk);

        // Directed arithmetic, WIDTH=8.
        run8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("add_cin",   8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
        run8("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        run8("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);
        @(negedge clk);

        // Back to back: start held high, operands changing every cycle.
        start_v[0] = 1'b1; sub_v[0] = 1'b0; cin_v[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            a_v[0] = 8'(i * 37 + 3);
            b_v[0] = 8'(i * 11);
            @(negedge clk);
            if (done8) done_at.push_back(i);
        end
        start_v[0] = 1'b0;
        check("b2b_done_count", done_at.size(), 3);
        if (done_at.size() >= 3) begin
            check("b2b_period_0", done_at[1] - done_at[0], 9);
            check("b2b_period_1", done_at[2] - done_at[1], 9);
        end
        repeat (12) @(negedge clk);

        // Reset in the middle of an operation.
        a_v[0] = 8'hAA; b_v[0] = 8'h55; sub_v[0] = 1'b0; cin_v[0] = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        check("midrun_reset", {busy8, done8, cout8, ovf8, sum8}, 12'h000);
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8) seen_done = 1'b1;
        end
        check("midrun_no_done", seen_done, 1'b0);
        run8("after_reset", 8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);

        // WIDTH=1: full-adder truth table, index = {a, b, cin}.
        fa_sum_tbl  = 8'b1001_0110;
        fa_cout_tbl = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            a_v[1] = {7'd0, i[2]}; b_v[1] = {7'd0, i[1]}; cin_v[1] = i[0];
            sub_v[1] = 1'b0; start_v[1] = 1'b1;
            @(negedge clk);
            start_v[1] = 1'b0;
            a_v[1] = ~a_v[1]; b_v[1] = ~b_v[1]; cin_v[1] = ~cin_v[1];
            check("w1_busy", busy1, 1'b1);
            @(negedge clk);
            check("w1_done", done1, 1'b1);
            check("w1_sum_cout", {sum1, cout1}, {fa_sum_tbl[i], fa_cout_tbl[i]});
        end
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
